// File: rtl/lsu_mem_master.sv
// lsu_mem_master: MEM-stage load/store initiator for the pipelined MIPS core.
// It turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into accesses on
// a word-addressed data memory. Sub-word stores become a read-modify-write
// that holds the pipeline for one extra cycle.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   req_valid/req_write/req_size/req_unsigned/req_addr/req_wdata
//                             request, sampled only while stall=0
//   stall                     pipeline hold (MERGE state)
//   load_data, load_valid     registered, extended load result and its pulse
//   fault                     one-cycle pulse for a rejected request
//   MemRead, MemWrite, Address, WriteData, ReadData
//                             word-addressed data memory port
module lsu_mem_master #(
    parameter int WORD_SHIFT = 2,
    parameter int MEM_WORDS  = 2101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        fault,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    typedef enum logic {IDLE, MERGE} state_t;

    state_t      state, state_nxt;
    logic [31:0] index;
    logic        bad, accept, reject, sub_store;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Read-modify-write context captured in the read cycle.
    logic [31:0] lat_word;
    logic [31:0] lat_idx;
    logic [1:0]  lat_lane;
    logic        lat_half;
    logic [15:0] lat_wdata;
    logic [31:0] merged;

    assign index = req_addr >> WORD_SHIFT;

    always_comb begin
        bad = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || (index >= 32'(MEM_WORDS));
    end

    assign accept    = (state == IDLE) && req_valid && !bad;
    assign reject    = (state == IDLE) && req_valid && bad;
    assign sub_store = accept && req_write && (req_size != 2'b10);

    // Little-endian lane select; a half-word starts at lane {addr[1],0}.
    assign ld_byte = ReadData[{req_addr[1:0], 3'b000} +: 8];
    assign ld_half = ReadData[{req_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (req_size)
            2'b00:   ld_ext = req_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = req_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = ReadData;
        endcase
    end

    // Per-lane merge: a lane takes new data only if the stored byte/half
    // covers it; the upper byte of a half goes to the odd lane.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        localparam logic [1:0] LANE = 2'(b);
        logic hit;
        assign hit = lat_half ? (lat_lane[1] == LANE[1]) : (lat_lane == LANE);
        assign merged[8*b +: 8] = !hit ? lat_word[8*b +: 8]
                                : (lat_half && LANE[0]) ? lat_wdata[15:8]
                                : lat_wdata[7:0];
    end

    always_comb begin
        state_nxt = state;
        stall     = (state == MERGE);
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    Address = index;
                    if (!req_write) begin
                        MemRead = 1'b1;
                    end else if (req_size == 2'b10) begin
                        MemWrite  = 1'b1;
                        WriteData = req_wdata;
                    end else begin
                        MemRead   = 1'b1;
                        state_nxt = MERGE;
                    end
                end
            end
            MERGE: begin
                MemWrite  = 1'b1;
                Address   = lat_idx;
                WriteData = merged;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset wins over everything, including a pending merge write.
        if (rst) begin
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            Address   = 32'h0;
            WriteData = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            fault      <= 1'b0;
            lat_word   <= 32'h0;
            lat_idx    <= 32'h0;
            lat_lane   <= 2'b00;
            lat_half   <= 1'b0;
            lat_wdata  <= 16'h0;
        end else begin
            state      <= state_nxt;
            load_valid <= accept && !req_write;
            fault      <= reject;
            if (accept && !req_write)
                load_data <= ld_ext;
            if (sub_store) begin
                lat_word  <= ReadData;
                lat_idx   <= index;
                lat_lane  <= req_addr[1:0];
                lat_half  <= req_size[0];
                lat_wdata <= req_wdata[15:0];
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    localparam int N = 2101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, load_valid, fault, MemRead, MemWrite;
    logic [31:0] load_data, Address, WriteData, ReadData;

    logic [31:0] mem [0:N-1];

    int n_cmp = 0;
    int n_bad = 0;

    lsu_mem_master #(.WORD_SHIFT(2), .MEM_WORDS(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .fault(fault),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on the clock edge.
    assign ReadData = (MemRead && Address < N) ? mem[Address] : 32'h0;
    always @(posedge clk)
        if (MemWrite && Address < N) mem[Address] <= WriteData;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        vld, wr, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        logic        e_rd, e_wr;
        logic [31:0] e_adr, e_wd;
        logic        e_lv, e_flt;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic vld, wr, uns, input logic [1:0] size,
                       input logic [31:0] addr, wdata,
                       input logic e_rd, e_wr, input logic [31:0] e_adr, e_wd,
                       input logic e_lv, e_flt, input logic [31:0] e_data);
        vec_t v;
        v = '{vld, wr, uns, size, addr, wdata, e_rd, e_wr, e_adr, e_wd, e_lv, e_flt, e_data};
        vq.push_back(v);
    endtask

    task automatic drive(input logic vld, wr, uns, input logic [1:0] size,
                         input logic [31:0] addr, wdata);
        @(negedge clk);
        req_valid = vld; req_write = wr; req_unsigned = uns;
        req_size = size; req_addr = addr; req_wdata = wdata;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_unsigned = 0; req_size = 0;
        req_addr = 0; req_wdata = 0;

        //   vld wr uns size   addr       wdata         rd wr adr wd            lv flt data
        add(1, 1, 0, 2'b10, 32'h10,   32'h8899AABB, 0, 1, 4, 32'h8899AABB, 0, 0, 32'h0);
        add(1, 0, 0, 2'b00, 32'h12,   32'h0,        1, 0, 4, 32'h0,        1, 0, 32'hFFFFFF99);
        add(1, 0, 1, 2'b00, 32'h12,   32'h0,        1, 0, 4, 32'h0,        1, 0, 32'h00000099);
        add(1, 0, 0, 2'b01, 32'h10,   32'h0,        1, 0, 4, 32'h0,        1, 0, 32'hFFFFAABB);
        add(1, 0, 1, 2'b01, 32'h12,   32'h0,        1, 0, 4, 32'h0,        1, 0, 32'h00008899);
        add(1, 0, 0, 2'b00, 32'h10,   32'h0,        1, 0, 4, 32'h0,        1, 0, 32'hFFFFFFBB);
        add(1, 0, 1, 2'b00, 32'h11,   32'h0,        1, 0, 4, 32'h0,        1, 0, 32'h000000AA);
        add(1, 0, 0, 2'b10, 32'h10,   32'h0,        1, 0, 4, 32'h0,        1, 0, 32'h8899AABB);
        add(1, 0, 0, 2'b10, 32'h11,   32'h0,        0, 0, 0, 32'h0,        0, 1, 32'h8899AABB);
        add(1, 1, 0, 2'b01, 32'h05,   32'h1234,     0, 0, 0, 32'h0,        0, 1, 32'h8899AABB);
        add(1, 0, 0, 2'b10, 32'h20D4, 32'h0,        0, 0, 0, 32'h0,        0, 1, 32'h8899AABB);
        add(1, 0, 0, 2'b11, 32'h10,   32'h0,        0, 0, 0, 32'h0,        0, 1, 32'h8899AABB);
        add(1, 0, 0, 2'b01, 32'h13,   32'h0,        0, 0, 0, 32'h0,        0, 1, 32'h8899AABB);
        add(0, 0, 0, 2'b10, 32'h10,   32'h0,        0, 0, 0, 32'h0,        0, 0, 32'h8899AABB);
        add(1, 1, 0, 2'b10, 32'h20,   32'h12345678, 0, 1, 8, 32'h12345678, 0, 0, 32'h8899AABB);
        add(1, 0, 0, 2'b10, 32'h20,   32'h0,        1, 0, 8, 32'h0,        1, 0, 32'h12345678);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst MemRead", 32'(MemRead), 0);
        chk("rst MemWrite", 32'(MemWrite), 0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst load_data", load_data, 0);
        chk("rst load_valid", 32'(load_valid), 0);
        chk("rst fault", 32'(fault), 0);
        chk("rst stall", 32'(stall), 0);

        foreach (vq[i]) begin
            drive(vq[i].vld, vq[i].wr, vq[i].uns, vq[i].size, vq[i].addr, vq[i].wdata);
            chk($sformatf("v%0d MemRead", i), 32'(MemRead), 32'(vq[i].e_rd));
            chk($sformatf("v%0d MemWrite", i), 32'(MemWrite), 32'(vq[i].e_wr));
            chk($sformatf("v%0d stall", i), 32'(stall), 0);
            if (vq[i].e_rd || vq[i].e_wr)
                chk($sformatf("v%0d Address", i), Address, vq[i].e_adr);
            if (vq[i].e_wr)
                chk($sformatf("v%0d WriteData", i), WriteData, vq[i].e_wd);
            @(posedge clk); #1;
            chk($sformatf("v%0d load_valid", i), 32'(load_valid), 32'(vq[i].e_lv));
            chk($sformatf("v%0d fault", i), 32'(fault), 32'(vq[i].e_flt));
            chk($sformatf("v%0d load_data", i), load_data, vq[i].e_data);
        end

        // SB 0x13 read-modify-write, then LW of the same word
        drive(1, 1, 0, 2'b00, 32'h13, 32'h000000CC);
        chk("sb T MemRead", 32'(MemRead), 1);
        chk("sb T MemWrite", 32'(MemWrite), 0);
        chk("sb T Address", Address, 4);
        chk("sb T stall", 32'(stall), 0);
        drive(1, 0, 0, 2'b10, 32'h20, 32'h0);   // must be ignored while stalled
        chk("sb T1 stall", 32'(stall), 1);
        chk("sb T1 MemWrite", 32'(MemWrite), 1);
        chk("sb T1 MemRead", 32'(MemRead), 0);
        chk("sb T1 Address", Address, 4);
        chk("sb T1 WriteData", WriteData, 32'hCC99AABB);
        @(posedge clk); #1;
        chk("sb T1 no load_valid", 32'(load_valid), 0);
        chk("sb T1 load_data held", load_data, 32'h12345678);
        drive(1, 0, 0, 2'b10, 32'h10, 32'h0);
        chk("lw T2 stall", 32'(stall), 0);
        chk("lw T2 MemRead", 32'(MemRead), 1);
        @(posedge clk); #1;
        chk("lw merged valid", 32'(load_valid), 1);
        chk("lw merged data", load_data, 32'hCC99AABB);

        // SH 0x22 with reset in the MERGE cycle
        drive(1, 1, 0, 2'b01, 32'h22, 32'h0000BEEF);
        chk("sh T MemRead", 32'(MemRead), 1);
        drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
        rst = 1'b1; #1;
        chk("sh rst MemWrite", 32'(MemWrite), 0);
        chk("sh rst Address", Address, 0);
        chk("sh rst WriteData", WriteData, 0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("sh rst stall", 32'(stall), 0);
        chk("sh rst load_data", load_data, 0);
        chk("sh rst load_valid", 32'(load_valid), 0);
        chk("sh rst fault", 32'(fault), 0);
        chk("sh rst word8", mem[8], 32'h12345678);
        drive(1, 0, 0, 2'b10, 32'h20, 32'h0);
        @(posedge clk); #1;
        chk("post rst lw", load_data, 32'h12345678);
        drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("idle load_valid", 32'(load_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator for the MEM stage of the pipelined MIPS core. Drives the word-addressed data memory port (MemRead, MemWrite, Address, WriteData, ReadData).
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
- Sub-word stores are done as read-modify-write, which stalls the pipeline for one cycle.
- Returns sign- or zero-extended load data and flags misaligned or out-of-range accesses.

Parameters:
- WORD_SHIFT, 2, right shift applied to a byte address to form the memory word index.
- MEM_WORDS, 2101, number of words in the data memory; any word index >= MEM_WORDS is a fault.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  access request this cycle; sampled only when stall=0.
- req_write  input  1  1=store, 0=load.
- req_size  input  2  00=byte, 01=half, 10=word; 11 is a fault.
- req_unsigned  input  1  1=zero-extend the load result (LBU/LHU).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- stall  output  1  pipeline hold; asserted in MERGE state.
- load_data  output  32  extended load result, registered.
- load_valid  output  1  one-cycle pulse when load_data is updated.
- fault  output  1  one-cycle pulse for a rejected access.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable; memory writes at the clk edge.
- Address  output  32  word index = req_addr >> WORD_SHIFT.
- WriteData  output  32  full word to write.
- ReadData  input  32  memory read data, combinational from Address/MemRead.

Behaviour:
- States: IDLE and MERGE.
- Reset (synchronous): state=IDLE; load_data=0, load_valid=0, fault=0; internal latches cleared.
  - While rst=1, MemRead, MemWrite, Address and WriteData are forced to 0 combinationally.
- Little-endian byte lanes: lane = req_addr[1:0]; a half-word occupies lanes {addr[1],0}+1 : {addr[1],0}.
- Fault conditions, checked in IDLE with req_valid=1:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index >= MEM_WORDS.
  - Response: no MemRead/MemWrite, fault=1 next cycle, load_valid=0, load_data unchanged.
- IDLE, valid load: MemRead=1 and Address=index combinationally in the same cycle. At the edge, load_data is set to the selected lane(s), sign- or zero-extended; load_valid=1 for the next cycle only. stall=0.
- IDLE, word store: MemWrite=1, WriteData=req_wdata, same cycle; single cycle, stall=0.
- IDLE, byte or half store:
  - Cycle T: MemRead=1 at index. At the edge, latch ReadData, lane, size, the low bits of req_wdata and the index; go to MERGE.
- MERGE (cycle T+1):
  - stall=1; pipeline holds and req_* are ignored.
  - MemWrite=1, Address=latched index, WriteData=latched word with only the target lane(s) replaced.
  - Return to IDLE at the edge; a new request is accepted at T+2.
- MemRead and MemWrite are never both high in a cycle.
- Back-to-back: loads and word stores are accepted every cycle. A load following a sub-word store to the same word returns the merged value.
- Reset during MERGE: no write that cycle (rst forces MemWrite=0); next state IDLE, merge discarded.
- req_valid=0 in IDLE: all memory controls 0; load_valid=0, fault=0 next cycle.

Test Plan:
- Preload word 4 = 32'h8899AABB, then LB addr 0x12 -> MemRead=1, Address=4 in cycle T; at T+1 load_valid=1 and load_data=32'hFFFFFF99. LBU at the same address -> 32'h00000099.
- LH addr 0x10 -> 32'hFFFFAABB. LHU addr 0x12 -> 32'h00008899.
- SB addr 0x13, wdata 32'h000000CC -> T: MemRead, Address=4; T+1: stall=1, MemWrite=1, WriteData=32'hCC99AABB. Then LW 0x10 at T+2 -> 32'hCC99AABB.
- LW addr 0x11, SH addr 0x05, LW addr 4*2101 -> no memory enables; fault pulses one cycle after each; load_data unchanged.
- SW 0x20 = 32'h12345678 followed by LW 0x20 on the next cycle -> no stall; load_valid at T+2 with 32'h12345678.
- SH 0x22 with rst=1 asserted in the MERGE cycle -> MemWrite=0; word 8 unchanged; state IDLE, stall=0; all outputs 0 after the edge.
